// File: rtl/serial_adder_sub.sv
// Bit-serial adder/subtractor: one full-add bit per clock through a carry flop.
// Operands enter on an in_valid/in_ready handshake; the result, carry-out and
// signed-overflow flag leave on an out_valid/out_ready handshake.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for operands, in_ready=1
// RUN   | adding one bit per edge, LSB first, busy=1
// DONE  | result held on sum/carry/overflow, out_valid=1 until out_ready
module serial_adder_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh, b_sh, s_sh, s_nxt;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt;
  logic             c, c_nxt, s_bit, last;
  logic             carry_q, overflow_q;

  // Single full-add cell operating on the LSBs of the operand shifters.
  always_comb begin
    s_bit = a_sh[0] ^ b_sh[0] ^ c;
    c_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
    last  = (cnt == CNT_W'(WIDTH - 1));
    // The new sum bit enters at the MSB so the LSB-first result lands aligned.
    s_nxt = s_sh >> 1;
    s_nxt[WIDTH-1] = s_bit;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; the final RUN edge is the one that consumes the MSB.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Operand/sum shifters, carry flop, bit counter and the held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh       <= '0;
      b_sh       <= '0;
      s_sh       <= '0;
      c          <= 1'b0;
      cnt        <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtract as A + ~B + 1: the +1 rides in as the initial carry.
            a_sh <= inA;
            b_sh <= in_sub ? ~inB : inB;
            c    <= in_sub;
            cnt  <= '0;
            s_sh <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          s_sh <= s_nxt;
          c    <= c_nxt;
          cnt  <= cnt + CNT_W'(1);
          if (last) begin
            // c still holds the carry into the MSB here.
            sum_q      <= s_nxt;
            carry_q    <= c_nxt;
            overflow_q <= c ^ c_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake and status outputs decode from state only.
  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_adder_sub.sv
// Bench for serial_adder_sub: directed WIDTH=8 cases plus randomised WIDTH=1
// and WIDTH=32 instances, all checked against an expected-result queue.
module tb_serial_adder_sub;

  typedef struct {
    logic [63:0] sum;
    logic        carry;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_mis = 0;
  exp_t exp_q[$];

  // WIDTH=8 instance
  logic       d8_in_valid = 0, d8_in_sub = 0, d8_out_ready = 0;
  logic [7:0] d8_inA = '0, d8_inB = '0;
  logic       d8_in_ready, d8_out_valid, d8_carry, d8_ovf, d8_busy;
  logic [7:0] d8_sum;

  serial_adder_sub #(.WIDTH(8)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(d8_in_valid), .in_ready(d8_in_ready),
    .in_sub(d8_in_sub), .inA(d8_inA), .inB(d8_inB), .out_valid(d8_out_valid),
    .out_ready(d8_out_ready), .sum(d8_sum), .carry(d8_carry),
    .overflow(d8_ovf), .busy(d8_busy));

  // WIDTH=1 instance
  logic       d1_in_valid = 0, d1_in_sub = 0, d1_out_ready = 0;
  logic [0:0] d1_inA = '0, d1_inB = '0;
  logic       d1_in_ready, d1_out_valid, d1_carry, d1_ovf, d1_busy;
  logic [0:0] d1_sum;

  serial_adder_sub #(.WIDTH(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .in_sub(d1_in_sub), .inA(d1_inA), .inB(d1_inB), .out_valid(d1_out_valid),
    .out_ready(d1_out_ready), .sum(d1_sum), .carry(d1_carry),
    .overflow(d1_ovf), .busy(d1_busy));

  // WIDTH=32 instance
  logic        d32_in_valid = 0, d32_in_sub = 0, d32_out_ready = 0;
  logic [31:0] d32_inA = '0, d32_inB = '0;
  logic        d32_in_ready, d32_out_valid, d32_carry, d32_ovf, d32_busy;
  logic [31:0] d32_sum;

  serial_adder_sub #(.WIDTH(32)) u_d32 (
    .clk(clk), .rst(rst), .in_valid(d32_in_valid), .in_ready(d32_in_ready),
    .in_sub(d32_in_sub), .inA(d32_inA), .inB(d32_inB), .out_valid(d32_out_valid),
    .out_ready(d32_out_ready), .sum(d32_sum), .carry(d32_carry),
    .overflow(d32_ovf), .busy(d32_busy));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: full-width two's-complement add, overflow from operand/result signs.
  function automatic exp_t ref_calc(input int w, input logic [63:0] a, input logic [63:0] b,
                                    input logic sub);
    exp_t        r;
    logic [63:0] mask, aa, bb;
    logic [64:0] full;
    mask   = (64'd1 << w) - 64'd1;
    aa     = a & mask;
    bb     = (sub ? ~b : b) & mask;
    full   = {1'b0, aa} + {1'b0, bb} + {64'd0, sub};
    r.sum  = full[63:0] & mask;
    r.carry = full[w];
    r.ovf  = (aa[w-1] == bb[w-1]) && (r.sum[w-1] != aa[w-1]);
    return r;
  endfunction

  function automatic exp_t mk(input logic [63:0] s, input logic c, input logic o);
    exp_t r;
    r.sum = s; r.carry = c; r.ovf = o;
    return r;
  endfunction

  // Present operands to the WIDTH=8 unit and measure edges until out_valid.
  task automatic d8_issue(input logic [7:0] a, input logic [7:0] b, input logic sub,
                          input bit keep_valid);
    int n;
    @(negedge clk);
    check("d8_in_ready_idle", 128'(d8_in_ready), 128'(1));
    d8_in_valid = 1; d8_inA = a; d8_inB = b; d8_in_sub = sub;
    @(posedge clk); #1;
    check("d8_busy_run", 128'({d8_busy, d8_in_ready}), 128'(2'b10));
    if (keep_valid) begin
      d8_inA = ~a; d8_inB = a; d8_in_sub = ~sub;
    end else begin
      d8_in_valid = 0;
    end
    n = 0;
    while (!d8_out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("d8_latency", 128'(n), 128'(8));
  endtask

  // Hold off the consumer for some cycles, then accept and compare the result.
  task automatic d8_collect(input int stall);
    exp_t e;
    e = mk(64'd0, 1'b0, 1'b0);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("d8_hold_result", 128'({d8_sum, d8_carry, d8_ovf}),
            128'({e.sum[7:0], e.carry, e.ovf}));
      check("d8_hold_hs", 128'({d8_out_valid, d8_in_ready}), 128'(2'b10));
    end
    @(negedge clk);
    d8_in_valid  = 0;
    d8_out_ready = 1;
    check("d8_result", 128'({d8_out_valid, d8_sum, d8_carry, d8_ovf}),
          128'({1'b1, e.sum[7:0], e.carry, e.ovf}));
    @(posedge clk); #1;
    d8_out_ready = 0;
    check("d8_in_ready_after", 128'({d8_in_ready, d8_out_valid}), 128'(2'b10));
  endtask

  task automatic rand_d1(input int nops);
    for (int i = 0; i < nops; i++) begin
      exp_t e;
      int   n;
      logic [0:0] a, b;
      logic s;
      a = 1'($urandom); b = 1'($urandom); s = 1'($urandom);
      d1_in_valid = 1; d1_inA = a; d1_inB = b; d1_in_sub = s;
      exp_q.push_back(ref_calc(1, {63'd0, a}, {63'd0, b}, s));
      @(posedge clk); #1;
      d1_in_valid = 0;
      n = 0;
      while (!d1_out_valid && n < 10) begin
        d1_out_ready = 1'($urandom);
        @(posedge clk); #1;
        n++;
      end
      d1_out_ready = 0;
      e = mk(64'd0, 1'b0, 1'b0);
      if (exp_q.size() != 0) e = exp_q.pop_front();
      check("d1_result", 128'({d1_out_valid, d1_sum, d1_carry, d1_ovf}),
            128'({1'b1, e.sum[0], e.carry, e.ovf}));
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      d1_out_ready = 1;
      @(posedge clk); #1;
      d1_out_ready = 0;
      check("d1_release", 128'({d1_out_valid, d1_in_ready}), 128'(2'b01));
    end
  endtask

  task automatic rand_d32(input int nops);
    for (int i = 0; i < nops; i++) begin
      exp_t e;
      int   n;
      logic [31:0] a, b;
      logic s;
      a = $urandom; b = $urandom; s = 1'($urandom);
      d32_in_valid = 1; d32_inA = a; d32_inB = b; d32_in_sub = s;
      exp_q.push_back(ref_calc(32, {32'd0, a}, {32'd0, b}, s));
      @(posedge clk); #1;
      d32_in_valid = 0;
      n = 0;
      while (!d32_out_valid && n < 40) begin
        d32_out_ready = 1'($urandom);
        @(posedge clk); #1;
        n++;
      end
      d32_out_ready = 0;
      e = mk(64'd0, 1'b0, 1'b0);
      if (exp_q.size() != 0) e = exp_q.pop_front();
      check("d32_result", 128'({d32_out_valid, d32_sum, d32_carry, d32_ovf}),
            128'({1'b1, e.sum[31:0], e.carry, e.ovf}));
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      d32_out_ready = 1;
      @(posedge clk); #1;
      d32_out_ready = 0;
      check("d32_release", 128'({d32_out_valid, d32_in_ready}), 128'(2'b01));
    end
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_in_ready", 128'(d8_in_ready), 128'(1));
    check("rst_out_valid_busy", 128'({d8_out_valid, d8_busy}), 128'(0));
    check("rst_result", 128'({d8_sum, d8_carry, d8_ovf}), 128'(0));
    check("rst_other_widths", 128'({d1_in_ready, d32_in_ready, d1_out_valid, d32_out_valid}),
          128'(4'b1100));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;

    // Plain add, carry/overflow edge cases, backpressure with stray in_valid
    exp_q.push_back(mk(64'h10, 1'b0, 1'b0));
    d8_issue(8'h0F, 8'h01, 1'b0, 1'b0);
    d8_collect(0);

    exp_q.push_back(mk(64'h00, 1'b1, 1'b0));
    d8_issue(8'hFF, 8'h01, 1'b0, 1'b0);
    d8_collect(1);

    exp_q.push_back(mk(64'h80, 1'b0, 1'b1));
    d8_issue(8'h7F, 8'h01, 1'b0, 1'b1);
    d8_collect(5);

    // Subtract
    exp_q.push_back(mk(64'hFE, 1'b0, 1'b0));
    d8_issue(8'h05, 8'h07, 1'b1, 1'b0);
    d8_collect(2);

    exp_q.push_back(mk(64'h7F, 1'b1, 1'b1));
    d8_issue(8'h80, 8'h01, 1'b1, 1'b0);
    d8_collect(0);

    // Asynchronous reset with cnt==3, between clock edges
    @(negedge clk);
    d8_in_valid = 1; d8_inA = 8'h0F; d8_inB = 8'h0F; d8_in_sub = 0;
    @(posedge clk); #1;
    d8_in_valid = 0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1;
    #1;
    check("midrun_rst_result", 128'({d8_sum, d8_carry, d8_ovf}), 128'(0));
    check("midrun_rst_hs", 128'({d8_in_ready, d8_out_valid, d8_busy}), 128'(3'b100));
    @(negedge clk);
    rst = 0;

    exp_q.push_back(mk(64'h02, 1'b0, 1'b0));
    d8_issue(8'h01, 8'h01, 1'b0, 1'b0);
    d8_collect(0);

    // Randomised narrow and wide builds
    @(negedge clk);
    rand_d1(1000);
    @(negedge clk);
    rand_d32(1000);

    check("queue_drained", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
